// File: rtl/piece_spawner.sv
// ---------------------------------------------------------------------------
// piece_spawner
//
// Purpose:
//   Picks each new falling tetromino and presents it at the spawn position.
//   A one-deep preview slot (next_id) is filled from a 16-bit Fibonacci
//   LFSR, one candidate per cycle. When a spawn request is accepted, the
//   preview becomes the live piece and the preview slot is refilled.
//
// Optional feature (macro BAG7_EN):
//   When BAG7_EN is defined, a 7-bag randomiser is added. Each id is then
//   accepted once per bag, and the bag clears after all seven ids have
//   been used. When BAG7_EN is undefined, only candidate 7 is rejected.
//
// Parameters:
//   SEED      - LFSR reset value. It must be non-zero.
//   SPAWN_X   - left column of the 4x4 window at spawn.
//   SPAWN_Y   - top row of the 4x4 window at spawn.
//   RETRY_MAX - number of consecutive rejects before a forced pick.
//
// Ports:
//   clk         in   system clock; all state changes on the rising edge
//   rst         in   synchronous reset, active-high
//   spawn_req   in   level request for a new piece
//   halt        in   game over / pause; blocks acceptance of requests
//   spawn_valid out  one-cycle pulse; the spawn outputs changed this cycle
//   piece_id    out  id of the spawned piece (I=0 O=1 T=2 S=3 Z=4 J=5 L=6)
//   float       out  4x4 bitmap, row-major; float[0] is the top-left cell
//   pos_x       out  spawn column (SPAWN_X after a spawn)
//   pos_y       out  spawn row (SPAWN_Y after a spawn)
//   next_id     out  preview piece id
//   busy        out  high while the preview slot is being (re)filled
//   dbg_state_o out  current FSM state (0 = PICK, 1 = READY)
//
// Handshake:
//   A request is taken on a rising edge where spawn_req=1, busy=0 and
//   halt=0. spawn_valid pulses on the following cycle. A request seen
//   while busy=1 or halt=1 is dropped, not queued. The requester keeps
//   spawn_req high until it sees spawn_valid.
// ---------------------------------------------------------------------------
module piece_spawner #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter logic [3:0]  SPAWN_X   = 4'd3,
    parameter logic [4:0]  SPAWN_Y   = 5'd19,
    parameter logic [3:0]  RETRY_MAX = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spawn_req,
    input  logic        halt,
    output logic        spawn_valid,
    output logic [2:0]  piece_id,
    output logic [0:15] float,
    output logic [3:0]  pos_x,
    output logic [4:0]  pos_y,
    output logic [2:0]  next_id,
    output logic        busy,
    output logic        dbg_state_o
);

    typedef enum logic {
        ST_PICK  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Spawn-orientation bitmaps. The MSB of each constant lands in float[0].
    function automatic logic [15:0] bitmap(input logic [2:0] id);
        logic [15:0] bm;
        case (id)
            3'd0:    bm = 16'h0F00; // I
            3'd1:    bm = 16'h6600; // O
            3'd2:    bm = 16'h4E00; // T
            3'd3:    bm = 16'h6C00; // S
            3'd4:    bm = 16'hC600; // Z
            3'd5:    bm = 16'h8E00; // J
            3'd6:    bm = 16'h2E00; // L
            default: bm = 16'h0000;
        endcase
        return bm;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  retry_q, retry_d;
    logic [2:0]  next_id_q, next_id_d;
    logic [2:0]  piece_id_q;
    logic [15:0] float_q;
    logic [3:0]  pos_x_q;
    logic [4:0]  pos_y_q;
    logic        spawn_valid_q;

    logic [2:0]  cand;
    logic        cand_ok;
    logic [2:0]  forced_id;
    logic [2:0]  pick_id;
    logic        pick_accept;
    logic        spawn_go;

    // ------------------------------------------------------------------
    // LFSR: free-running. The candidate is the low three bits of the
    // current value.
    // ------------------------------------------------------------------
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign cand = lfsr_q[2:0];

`ifdef BAG7_EN
    logic [6:0] mask_q, mask_d, mask_set;
    logic [7:0] used8;
    logic [2:0] lowest_free;

    // Bit 7 is always set, so that candidate 7 is rejected by the same test
    // that rejects ids already in the bag.
    assign used8 = {1'b1, mask_q};

    // The bag clears on the accept that fills it, so a free id always exists.
    always_comb begin
        lowest_free = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (!mask_q[i]) begin
                lowest_free = 3'(i);
            end
        end
    end

    assign cand_ok   = !used8[cand];
    assign forced_id = lowest_free;
    assign mask_set  = mask_q | (7'd1 << pick_id);

    always_comb begin
        mask_d = mask_q;
        if (pick_accept) begin
            mask_d = (mask_set == 7'h7F) ? 7'h00 : mask_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= 7'h00;
        end else begin
            mask_q <= mask_d;
        end
    end
`else
    assign cand_ok   = (cand != 3'd7);
    assign forced_id = 3'd0;
`endif

    // A rejected candidate at the retry cap still ends the pick, using the
    // forced id.
    assign pick_id = cand_ok ? cand : forced_id;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_PICK;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PICK:  if (pick_accept) state_d = ST_READY;
            ST_READY: if (spawn_go)    state_d = ST_PICK;
            default:  state_d = ST_PICK;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        busy        = (state_q == ST_PICK);
        dbg_state_o = state_q;
        pick_accept = (state_q == ST_PICK) && (cand_ok || (retry_q == RETRY_MAX));
        spawn_go    = (state_q == ST_READY) && spawn_req && !halt;
    end

    // ------------------------------------------------------------------
    // Preview slot and retry counter
    // ------------------------------------------------------------------
    always_comb begin
        retry_d   = retry_q;
        next_id_d = next_id_q;
        if (state_q == ST_PICK) begin
            if (pick_accept) begin
                retry_d   = 4'd0;
                next_id_d = pick_id;
            end else begin
                retry_d   = retry_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q        <= SEED;
            retry_q       <= 4'd0;
            next_id_q     <= 3'd0;
            piece_id_q    <= 3'd0;
            float_q       <= 16'h0000;
            pos_x_q       <= 4'd0;
            pos_y_q       <= 5'd0;
            spawn_valid_q <= 1'b0;
        end else begin
            lfsr_q        <= lfsr_d;
            retry_q       <= retry_d;
            next_id_q     <= next_id_d;
            spawn_valid_q <= spawn_go;
            // float and the position registers hold their values between spawns.
            if (spawn_go) begin
                piece_id_q <= next_id_q;
                float_q    <= bitmap(next_id_q);
                pos_x_q    <= SPAWN_X;
                pos_y_q    <= SPAWN_Y;
            end
        end
    end

    assign spawn_valid = spawn_valid_q;
    assign piece_id    = piece_id_q;
    assign float       = float_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign next_id     = next_id_q;

endmodule

// File: tb/tb_piece_spawner.sv
// ---------------------------------------------------------------------------
// tb_piece_spawner
//
// Purpose:
//   Self-checking bench for piece_spawner. The reference model precomputes
//   the LFSR sequence indexed by the number of clock edges since reset.
//   From that sequence it derives the piece each refill should pick and how
//   many cycles the refill should take. The model applies the rejection,
//   retry-cap and bag rules directly to the sequence.
// ---------------------------------------------------------------------------
module tb_piece_spawner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spawn_req = 1'b0;
    logic        halt = 1'b0;
    logic        spawn_valid;
    logic [2:0]  piece_id;
    logic [0:15] float;
    logic [3:0]  pos_x;
    logic [4:0]  pos_y;
    logic [2:0]  next_id;
    logic        busy;
    logic        dbg_state_o;

    piece_spawner dut (
        .clk         (clk),
        .rst         (rst),
        .spawn_req   (spawn_req),
        .halt        (halt),
        .spawn_valid (spawn_valid),
        .piece_id    (piece_id),
        .float       (float),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .next_id     (next_id),
        .busy        (busy),
        .dbg_state_o (dbg_state_o)
    );

    // Clock
    always #5 clk = ~clk;

    // Counts clock edges since reset released. This is the index of the LFSR
    // value that is live in the current cycle.
    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Reference data
    logic [15:0] seq [0:4095];
    logic [15:0] bm  [0:6] = '{16'h0F00, 16'h6600, 16'h4E00, 16'h6C00,
                               16'hC600, 16'h8E00, 16'h2E00};
    logic [6:0]  m_mask = 7'h00;
    int          exp_next = 0;
    int          last_id = 0;
    int          hist[$];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Simulates a refill that starts with LFSR index k. Returns the chosen
    // id and the number of cycles the refill takes.
    function automatic void model_pick(input int k, output int id, output int n);
        int  retries;
        bit  done;
        int  c;
        bit  ok;
        retries = 0;
        done = 0;
        id = 0;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (!done) begin
                c = int'(seq[k + i][2:0]);
`ifdef BAG7_EN
                ok = (c != 7) && !m_mask[c];
`else
                ok = (c != 7);
`endif
                if (ok) begin
                    id = c;
                    n = i + 1;
                    done = 1;
                end else if (retries == 15) begin
                    id = 0;
`ifdef BAG7_EN
                    for (int b = 6; b >= 0; b--) if (!m_mask[b]) id = b;
`endif
                    n = i + 1;
                    done = 1;
                end else begin
                    retries++;
                end
            end
        end
`ifdef BAG7_EN
        m_mask[id] = 1'b1;
        if (m_mask == 7'h7F) m_mask = 7'h00;
`endif
    endfunction

    // Call at the first negedge of a refill (busy=1). Waits, with a bound,
    // until busy drops.
    task automatic wait_pick(input string tag, input int k);
        int id, n, g;
        model_pick(k, id, n);
        g = 0;
        while (busy && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk({tag, "_pick_cycles"}, 32'(cyc - k), 32'(n));
        chk({tag, "_next_id"}, 32'(next_id), 32'(id));
        exp_next = id;
    endtask

    // Call at a negedge with busy=0. Raises the request and checks the spawn.
    // If pulse_busy is set, it holds the request one more cycle, into the
    // refill, where the DUT must ignore it.
    task automatic do_spawn(input string tag, input bit pulse_busy);
        int k;
        spawn_req = 1'b1;
        @(negedge clk);
        chk({tag, "_valid"}, 32'(spawn_valid), 32'd1);
        chk({tag, "_piece_id"}, 32'(piece_id), 32'(exp_next));
        chk({tag, "_float"}, 32'(float), 32'(bm[exp_next]));
        chk({tag, "_pos_x"}, 32'(pos_x), 32'd3);
        chk({tag, "_pos_y"}, 32'(pos_y), 32'd19);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        last_id = exp_next;
        hist.push_back(exp_next);
        k = cyc;
        if (pulse_busy) @(negedge clk);
        spawn_req = 1'b0;
        wait_pick(tag, k);
        chk({tag, "_valid_drop"}, 32'(spawn_valid), 32'd0);
        chk({tag, "_float_hold"}, 32'(float), 32'(bm[last_id]));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(spawn_valid), 32'd0);
        chk({tag, "_piece_id"}, 32'(piece_id), 32'd0);
        chk({tag, "_float"}, 32'(float), 32'd0);
        chk({tag, "_pos_x"}, 32'(pos_x), 32'd0);
        chk({tag, "_pos_y"}, 32'(pos_y), 32'd0);
        chk({tag, "_next_id"}, 32'(next_id), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // Scenario 1: the first refill after reset is one cycle and yields O.
    task automatic scen_first(input string tag);
        chk({tag, "_busy_first"}, 32'(busy), 32'd1);
        wait_pick(tag, cyc);
        chk({tag, "_first_preview"}, 32'(next_id), 32'd1);
        chk({tag, "_first_valid"}, 32'(spawn_valid), 32'd0);
        chk({tag, "_first_float"}, 32'(float), 32'd0);
    endtask

    initial begin
        int r;
        logic [6:0] seen;

        seq[0] = 16'hACE1;
        for (int i = 1; i < 4096; i++)
            seq[i] = {seq[i-1][14:0], seq[i-1][15] ^ seq[i-1][13] ^ seq[i-1][12] ^ seq[i-1][10]};

        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        m_mask = 7'h00;

        // Scenario 1
        scen_first("s1");

        // Scenario 2: the first spawn is O, then candidates 7,7,6 give L in 3 cycles.
        do_spawn("s2", 1'b0);
        chk("s2_preview_L", 32'(next_id), 32'd6);
        chk("s2_cycle_idx", 32'(cyc), 32'd5);

        // Scenario 3: halt with the request held blocks the spawn.
        halt = 1'b1;
        spawn_req = 1'b1;
        r = $urandom_range(2, 5);
        for (int i = 0; i < r; i++) begin
            @(negedge clk);
            chk("s3_halt_valid", 32'(spawn_valid), 32'd0);
            chk("s3_halt_busy", 32'(busy), 32'd0);
            chk("s3_halt_piece", 32'(piece_id), 32'(last_id));
        end
        halt = 1'b0;
        do_spawn("s3", 1'b0);

        // Scenario 4: a request held into the refill is ignored.
        do_spawn("s4", 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("s4_no_spawn", 32'(spawn_valid), 32'd0);
            chk("s4_ready", 32'(busy), 32'd0);
        end

        // Spawns continue with random idle gaps, up to 14 spawns in total.
        while (hist.size() < 14) begin
            r = $urandom_range(0, 3);
            repeat (r) @(negedge clk);
            do_spawn("rnd", 1'b0);
        end

`ifdef BAG7_EN
        // Scenario 5: each group of seven consecutive spawns is a full bag.
        for (int g = 0; g < 2; g++) begin
            seen = 7'h00;
            for (int j = 0; j < 7; j++) seen[hist[g*7 + j]] = 1'b1;
            chk("s5_bag_group", 32'(seen), 32'h7F);
        end
`endif
        chk("hist_len", 32'(hist.size()), 32'd14);

        // Scenario 6: reset during a refill wins, and the sequence restarts.
        spawn_req = 1'b1;
        @(negedge clk);
        chk("s6_spawn", 32'(spawn_valid), 32'd1);
        spawn_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("s6_rst");
        rst = 1'b0;
        m_mask = 7'h00;
        hist.delete();
        scen_first("s6");
        do_spawn("s6_re", 1'b0);
        chk("s6_preview_L", 32'(next_id), 32'd6);

        // Reset on the same edge as an accepted request: no spawn pulse.
        spawn_req = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_req");
        spawn_req = 1'b0;
        rst = 1'b0;
        m_mask = 7'h00;
        scen_first("rst_req");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/piece_spawner.md
Name: piece_spawner

Overview:
Generates each new falling tetromino and presents it at the spawn position. Its float/pos_y outputs feed the game-over checker directly, and also feed the board/motion logic. It keeps a one-deep preview of the next piece for the HUD. Piece selection uses a 16-bit LFSR, with an optional 7-bag randomiser.

Parameters:
SEED, 16'hACE1, LFSR reset value (must be non-zero)
SPAWN_X, 4'd3, column of the 4x4 window's left edge at spawn
SPAWN_Y, 5'd19, row of the 4x4 window's top row at spawn (top visible row of the 20-row board)
RETRY_MAX, 4'd15, consecutive rejected candidates before forced pick

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
spawn_req  input  1  level; request a new piece; accepted only when busy=0 and halt=0
halt  input  1  game over / paused; blocks acceptance, picking continues
spawn_valid  output  1  one-cycle pulse: float/piece_id/pos_* updated this cycle
piece_id  output  3  id of the spawned piece: I=0 O=1 T=2 S=3 Z=4 J=5 L=6
float  output  [0:15]  4x4 bitmap of the spawned piece, row-major, bit 0 = top-left
pos_x  output  4  = SPAWN_X on spawn
pos_y  output  5  = SPAWN_Y on spawn
next_id  output  3  preview piece id
busy  output  1  1 while the preview slot is being (re)filled

Behaviour:
- Reset values: spawn_valid=0, piece_id=0, float=16'h0000, pos_x=0, pos_y=0, next_id=0, busy=1; state=PICK; lfsr=SEED; bag mask=0; retry count=0.
- LFSR (Fibonacci):
  - fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - Advances on every clock edge except during reset.
  - The candidate is the current register's l[2:0].
- State PICK (busy=1), one candidate per cycle:
  - Reject if the candidate is 7 (or, with the bag option, already used); on reject, retry count +1.
  - On accept: next_id<=candidate, retry count<=0, state<=READY.
  - When retry count==RETRY_MAX and the candidate is rejected again: force accept of the lowest unused id (id 0 without the bag option).
- State READY (busy=0):
  - If spawn_req && !halt, all on the same edge: float<=bitmap(next_id), piece_id<=next_id, pos_x<=SPAWN_X, pos_y<=SPAWN_Y, spawn_valid<=1 for one cycle, state<=PICK.
  - Result: spawn outputs are valid one cycle after the request is sampled.
- Requests while busy=1 or halt=1 are ignored, not queued. The requester holds spawn_req until spawn_valid.
- float holds its value between spawns.
- Spawn bitmaps (row-major, 16'h):
  - I=0F00, O=6600, T=4E00, S=6C00, Z=C600, J=8E00, L=2E00.
- Reset asserted mid-PICK or on a request edge: reset wins; no spawn_valid pulse.
- After reset deassertion, the first PICK cycle evaluates lfsr=SEED.

Optional Feature:
Macro BAG7_EN.
- Defined:
  - A 7-bit used mask; a candidate is accepted only if its bit is clear, then the bit is set.
  - When the mask reaches 7'h7F after an accept, it clears to 0 on the same edge.
  - Result: every 7 consecutive previews contain each id exactly once.
  - Forced pick after the retry cap takes the lowest clear bit.
- Undefined: no mask; only candidate 7 is rejected; forced pick yields id 0.

Test Plan:
1. Reset with SEED=16'hACE1, deassert -> busy=1 for one cycle (candidate 1); then next_id=1 (O), busy=0, spawn_valid=0, float=0.
2. spawn_req=1 in the first READY cycle -> next edge: spawn_valid=1 for exactly one cycle, piece_id=1, float=16'h6600, pos_x=3, pos_y=19, busy=1. Then candidates 7, 7, 6 (lfsr 0xB387, 0x670F, 0xCE1E) -> next_id=6, busy=0.
3. halt=1 with spawn_req held high in READY -> no spawn_valid and outputs unchanged; drop halt -> spawn one cycle later.
4. spawn_req pulsed while busy=1 -> ignored; no spawn_valid once READY unless the request is re-asserted.
5. BAG7_EN defined: 14 back-to-back spawns -> ids 0..6 each appear exactly once in spawns 1-7 and again in spawns 8-14. Each float matches its bitmap table entry.
6. Assert rst during PICK -> next cycle: all outputs at reset values, lfsr=SEED; sequence repeats scenario 1 exactly.
